uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart to the team's UART receiver in the same test/example infrastructure.
- Accepts one byte per valid/ready handshake and shifts it out on tx_pin: 8N1 by default, LSB first, with configurable stop bits.
- Sits between a byte source (test FSM or FIFO) and the board serial pin.
- Bit period is derived from the clock frequency and baud rate, matching the receiver's timing model.

Parameters:
- CLK_FRE, 50, clock frequency in MHz.
- BAUD_RATE, 115200, serial baud rate.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active low.
- tx_data  input  8  byte to transmit; sampled only on the accept edge.
- tx_data_valid  input  1  source has a byte.
- tx_data_ready  output  1  transmitter can accept a byte; high exactly when state is S_IDLE.
- tx_busy  output  1  high whenever state is not S_IDLE.
- tx_pin  output  1  serial output, registered; idle level is high.

Behaviour:
- Derived values:
  - CYCLE = CLK_FRE*1000000/BAUD_RATE, computed as an integer.
  - CYCLE must be at least 2 and at most 65535.
  - cycle_cnt is 16 bits wide; bit_cnt is 3 bits wide.
- Reset (asynchronous, takes effect immediately):
  - state = S_IDLE, tx_pin = 1, tx_data_ready = 1, tx_busy = 0.
  - shift register and all counters = 0.
- Reset mid-frame: the frame is abandoned and tx_pin returns high at once. No partial byte is retransmitted after reset is released.
- States: S_IDLE, S_START, S_SEND_BYTE, S_PARITY (present only with the macro), S_STOP.
- S_IDLE:
  - tx_pin = 1.
  - Accept occurs on a rising edge where tx_data_valid && tx_data_ready.
  - On that same edge: tx_data is latched into the shift register, cycle_cnt is cleared, tx_pin goes to 0, and state moves to S_START.
- S_START:
  - tx_pin is held at 0 for exactly CYCLE clocks, counted from the accept edge.
  - At cycle_cnt == CYCLE-1: move to S_SEND_BYTE, drive tx_pin = data bit 0, clear cycle_cnt.
- S_SEND_BYTE:
  - Each data bit is held for CYCLE clocks, LSB first.
  - At cycle_cnt == CYCLE-1 with bit_cnt < 7: increment bit_cnt and drive the next bit.
  - At cycle_cnt == CYCLE-1 with bit_cnt == 7: move to S_PARITY if the macro is defined, otherwise to S_STOP.
- S_STOP:
  - tx_pin = 1 for STOP_BITS*CYCLE clocks.
  - At the terminal count: move to S_IDLE, and tx_data_ready rises on that edge.
- Frame length: from accept edge to tx_data_ready high is (9 + STOP_BITS)*CYCLE clocks, or (10 + STOP_BITS)*CYCLE with parity compiled in.
- Back-to-back transfers: if tx_data_valid stays high, the next accept happens on the first S_IDLE cycle. The idle gap between frames is exactly 1 clock; no extra stop time is inserted.
- tx_data may change while busy without affecting the frame in flight.
- tx_data_valid while busy is ignored. The source must hold valid and data until accepted.
- No glitches on tx_pin: it changes only on bit boundaries.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - S_PARITY is inserted between the last data bit and S_STOP, lasting CYCLE clocks.
  - tx_pin = ^byte XOR PARITY_ODD, computed from the latched byte.
- Undefined:
  - No S_PARITY state and no parity logic; the frame is 8N1 or 8N2.
  - PARITY_ODD has no effect.

Test Plan (CLK_FRE=1, BAUD_RATE=100000, so CYCLE=10):
- Single byte 0xA5, STOP_BITS=1:
  - tx_pin sequence, 10 clocks per bit: 0,1,0,1,0,0,1,0,1,1.
  - tx_data_ready low for 100 clocks after accept.
  - tx_busy mirrors it.
- Back-to-back 0x00 then 0xFF with valid held high:
  - Second start bit begins 1 clock after first stop bit ends.
  - Decoding by the uart_rx model yields 0x00 then 0xFF.
- STOP_BITS=2, byte 0x3C: stop level high for 20 clocks; ready returns 110 clocks after accept.
- rst_n pulsed low at clock 45 of a 0x81 frame:
  - tx_pin is 1 immediately, state is S_IDLE, ready is 1.
  - After release, no activity until a new valid.
- tx_data changed from 0x55 to 0xAA at clock 5 after accepting 0x55: 0x55 is transmitted.
- With UART_TX_PARITY_EN, byte 0x07:
  - PARITY_ODD=0 gives parity bit 1; PARITY_ODD=1 gives 0.
  - Frame is 110 clocks with STOP_BITS=1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (8N1/8N2, LSB first) with a valid/ready byte input.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_pin
);
  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] C_LAST = 16'(CYCLE - 1);
  localparam logic [2:0]  S_LAST = 3'(STOP_BITS - 1);

  if (CYCLE < 2 || CYCLE > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_BYTE,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cycle_cnt;
  logic [2:0]  r_bit_cnt, w_bit_nxt;
  logic [7:0]  r_shift;
  logic        w_cyc_end, w_accept, w_pin_nxt;

  assign w_cyc_end = r_cycle_cnt == C_LAST;
  assign w_accept  = tx_data_valid && r_state == S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cycle_cnt <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      tx_pin      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cycle_cnt <= (r_state == S_IDLE || w_cyc_end) ? '0 : r_cycle_cnt + 16'd1;
      r_bit_cnt   <= w_bit_nxt;
      tx_pin      <= w_pin_nxt;
      if (w_accept) r_shift <= tx_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      w_state_nxt = w_accept ? S_START : S_IDLE;
      S_START:     w_state_nxt = w_cyc_end ? S_SEND_BYTE : S_START;
`ifdef UART_TX_PARITY_EN
      S_SEND_BYTE: w_state_nxt = (w_cyc_end && r_bit_cnt == 3'd7) ? S_PARITY : S_SEND_BYTE;
      S_PARITY:    w_state_nxt = w_cyc_end ? S_STOP : S_PARITY;
`else
      S_SEND_BYTE: w_state_nxt = (w_cyc_end && r_bit_cnt == 3'd7) ? S_STOP : S_SEND_BYTE;
`endif
      S_STOP:      w_state_nxt = (w_cyc_end && r_bit_cnt == S_LAST) ? S_IDLE : S_STOP;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // bit_cnt indexes data bits in S_SEND_BYTE and counts stop bits in S_STOP
  always_comb begin
    tx_data_ready = r_state == S_IDLE;
    tx_busy       = r_state != S_IDLE;
    w_bit_nxt     = (r_state != w_state_nxt) ? 3'd0 :
                    (w_cyc_end && (r_state == S_SEND_BYTE || r_state == S_STOP)) ? r_bit_cnt + 3'd1 :
                    r_bit_cnt;
    w_pin_nxt     = 1'b1;
    case (w_state_nxt)
      S_START:     w_pin_nxt = 1'b0;
      S_SEND_BYTE: w_pin_nxt = r_shift[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY:    w_pin_nxt = ^r_shift ^ 1'(PARITY_ODD);
`endif
      default:     w_pin_nxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized bench comparing two uart_tx instances (1 and 2 stop bits)
// against a per-cycle frame model built from the serial format rules.
module tb_uart_tx;
  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] valid = '0;
  logic [7:0] data [2];
  logic [1:0] ready, busy, pin;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[0]), .tx_data_valid(valid[0]),
    .tx_data_ready(ready[0]), .tx_busy(busy[0]), .tx_pin(pin[0]));

  uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[1]), .tx_data_valid(valid[1]),
    .tx_data_ready(ready[1]), .tx_busy(busy[1]), .tx_pin(pin[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // instance d has d+1 stop bits and PARITY_ODD = d
  function automatic logic exp_bit(input int d, input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (PB == 1 && j == 9) return 1'(($countones(b) % 2) ^ d);
    return 1'b1;
  endfunction

  function automatic int frame_len(input int d);
    return (9 + PB + d + 1) * C;
  endfunction

  task automatic send(input int d, input logic [7:0] b, input bit keep,
                      input int chg_at, input int rst_at);
    int waited = 0;
    logic [7:0] rx = '0;
    while (!ready[d] && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", 32'(ready[d]), 1);
    data[d]  = b;
    valid[d] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < frame_len(d); k++) begin
      @(negedge clk);
      if (k == 0 && !keep) valid[d] = 1'b0;
      if (k == chg_at) data[d] = ~b;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_pin", 32'(pin[d]), 1);
        check("rst_ready", 32'(ready[d]), 1);
        check("rst_busy", 32'(busy[d]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          check("post_rst_pin", 32'(pin[d]), 1);
          check("post_rst_ready", 32'(ready[d]), 1);
        end
        return;
      end
      check("pin", 32'(pin[d]), 32'(exp_bit(d, b, k / C)));
      check("ready_low", 32'(ready[d]), 0);
      check("busy_high", 32'(busy[d]), 1);
      if (k % C == C / 2 && k / C >= 1 && k / C <= 8) rx[k/C-1] = pin[d];
    end
    @(negedge clk);
    check("ready_end", 32'(ready[d]), 1);
    check("busy_end", 32'(busy[d]), 0);
    check("pin_idle", 32'(pin[d]), 1);
    check("rx_byte", 32'(rx), 32'(b));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit keep;
    data[0] = '0;
    data[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_pin", 32'(pin[i]), 1);
      check("reset_ready", 32'(ready[i]), 1);
      check("reset_busy", 32'(busy[i]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'hA5, 0, -1, -1);
    send(0, 8'h00, 1, -1, -1);
    send(0, 8'hFF, 0, -1, -1);
    send(1, 8'h3C, 0, -1, -1);
    send(0, 8'h81, 0, -1, 45);
    send(0, 8'h55, 0, 5, -1);
    send(0, 8'h07, 0, -1, -1);
    send(1, 8'h07, 0, -1, -1);
    keep = 0;
    d = 0;
    for (int i = 0; i < 24; i++) begin
      if (!keep) begin
        d = int'($urandom_range(1, 0));
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      keep = (i < 23) ? bit'($urandom_range(1, 0)) : 1'b0;
      send(d, 8'($urandom), keep, ($urandom_range(3, 0) == 0) ? int'($urandom_range(60, 1)) : -1, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
